// File: rtl/srlzr_tx_sched.sv
// srlzr_tx_sched: round-robin arbiter that feeds one PISO serializer.
// Define TXSCHED_STATS_EN to add the 16-bit frame_cnt output.

module srlzr_tx_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [DATA_WIDTH-1:0]         ser_buff,
  output logic                          ser_load,
  input  logic                          ser_ready,
  input  logic                          ser_tx_active,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err,
  input  logic                          err_clr
`ifdef TXSCHED_STATS_EN
  ,
  output logic [15:0]                   frame_cnt
`endif
);

  localparam int GW   = $clog2(NUM_REQ);
  localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TMO_L = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_L = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         ptr_q, ptr_d;
  logic [GW-1:0]         gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] buff_q, buff_d;
  logic                  load_q, load_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic                  found;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         idx;
  logic                  done_exit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last winner, so it becomes lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign done_exit = (state_q == S_WAIT_DONE)
                   && !ser_tx_active && ser_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    buff_d  = buff_q;
    load_d  = 1'b0;
    ack_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && ser_ready && found) begin
          state_d     = S_LOAD;
          buff_d      = words[pick];
          gnt_d       = pick;
          ptr_d       = pick;
          ack_d[pick] = 1'b1;
          load_d      = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (ser_tx_active) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_L) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (done_exit) begin
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_L) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_L) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ERR: begin
        if (err_clr) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= GW'(NUM_REQ - 1);
      gnt_q   <= '0;
      buff_q  <= '0;
      load_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      buff_q  <= buff_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign req_ack  = ack_q;
  assign ser_buff = buff_q;
  assign ser_load = load_q;
  assign grant_id = gnt_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

`ifdef TXSCHED_STATS_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
    end else if (done_exit) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule
